// File: rtl/awb_gain_scheduler_pkg.sv
// Shared definitions for the AWB gain scheduler slice.
// Widths of the channel sums, the Q8.8 gain format and the divider
// dividend, the unity gain constant and the scheduler FSM state type.
package awb_pkg;

  localparam int unsigned Q_W        = 16;
  localparam int unsigned SUM_W      = 32;
  localparam int unsigned DIVIDEND_W = 40;

  localparam logic [Q_W-1:0] GAIN_1X = 16'd256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_R,
    S_WAIT_R,
    S_START_B,
    S_WAIT_B,
    S_COMMIT
  } state_t;

endpackage

// File: rtl/awb_gain_scheduler_if.sv
// Bundle between the AWB statistics / gain-apply side and the gain scheduler.
//   enable_i, frame_done_i, r/g/b_sum_i : statistics side -> scheduler
//   r/g/b_gain_o (Q8.8), gain_valid_o,
//   busy_o, overrun_o                   : scheduler -> gain-apply side
// Modports: master = statistics/consumer side, slave = scheduler.
interface awb_gain_scheduler_if;
  import awb_pkg::*;

  logic             enable_i;
  logic             frame_done_i;
  logic [SUM_W-1:0] r_sum_i;
  logic [SUM_W-1:0] g_sum_i;
  logic [SUM_W-1:0] b_sum_i;
  logic [Q_W-1:0]   r_gain_o;
  logic [Q_W-1:0]   g_gain_o;
  logic [Q_W-1:0]   b_gain_o;
  logic             gain_valid_o;
  logic             busy_o;
  logic             overrun_o;

  modport master (
    output enable_i, frame_done_i, r_sum_i, g_sum_i, b_sum_i,
    input  r_gain_o, g_gain_o, b_gain_o, gain_valid_o, busy_o, overrun_o
  );

  modport slave (
    input  enable_i, frame_done_i, r_sum_i, g_sum_i, b_sum_i,
    output r_gain_o, g_gain_o, b_gain_o, gain_valid_o, busy_o, overrun_o
  );

endinterface

// File: rtl/awb_gain_scheduler_divider.sv
// awb_seq_divider: restoring radix-2 unsigned 40/32 divider.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, dividend/divisor sampled with it
//   dividend  : 40-bit unsigned
//   divisor   : 32-bit unsigned (zero is not special-cased here)
//   done      : one-cycle pulse DIV_CYCLES cycles after start
//   quotient  : 40-bit result, stable from done until the next start
module awb_seq_divider
  import awb_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [SUM_W-1:0]      divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  logic [SUM_W-1:0]      rem;
  logic [SUM_W-1:0]      dsr;
  logic [DIVIDEND_W-1:0] quo;
  logic [CNT_W-1:0]      cnt;
  logic                  running;

  logic [SUM_W-1:0]      rem_src;
  logic [SUM_W-1:0]      dsr_src;
  logic [DIVIDEND_W-1:0] quo_src;
  logic [SUM_W:0]        trial;
  logic [SUM_W-1:0]      rem_nxt;
  logic [DIVIDEND_W-1:0] quo_nxt;

  // The first iteration runs on the start edge straight from the inputs,
  // so DIV_CYCLES iterations finish in time for done on cycle DIV_CYCLES.
  always_comb begin
    rem_src = start ? '0       : rem;
    quo_src = start ? dividend : quo;
    dsr_src = start ? divisor  : dsr;
    trial   = {rem_src, quo_src[DIVIDEND_W-1]};
    rem_nxt = trial[SUM_W-1:0];
    quo_nxt = {quo_src[DIVIDEND_W-2:0], 1'b0};
    if (trial >= {1'b0, dsr_src}) begin
      // trial < 2*divisor, so the difference always fits in SUM_W bits
      rem_nxt    = trial[SUM_W-1:0] - dsr_src;
      quo_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      dsr     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= rem_nxt;
        quo     <= quo_nxt;
        dsr     <= divisor;
        cnt     <= CNT_W'(DIV_CYCLES - 1);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/awb_gain_scheduler.sv
// awb_gain_scheduler: per-frame white-balance gain computation.
// Latches the R/G/B sums on frame_done, computes R and B gains as
// (G<<8)/R and (G<<8)/B on one shared sequential divider, clamps them,
// IIR-smooths them and commits all three Q8.8 gains in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : awb_gain_scheduler_if.slave (sums in, gains/status out)
module awb_gain_scheduler
  import awb_pkg::*;
#(
  parameter int unsigned GAIN_MIN     = 128,
  parameter int unsigned GAIN_MAX     = 1024,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned DIV_CYCLES   = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  awb_gain_scheduler_if.slave  bus
);

  state_t                state;
  logic [SUM_W-1:0]      r_lat;
  logic [SUM_W-1:0]      g_lat;
  logic [SUM_W-1:0]      b_lat;
  logic [Q_W-1:0]        r_tgt;
  logic [Q_W-1:0]        b_tgt;
  logic [Q_W-1:0]        r_gain;
  logic [Q_W-1:0]        g_gain;
  logic [Q_W-1:0]        b_gain;
  logic                  gain_valid;
  logic                  busy;
  logic                  overrun;

  logic                  div_start;
  logic [SUM_W-1:0]      div_divisor;
  logic                  div_done;
  logic [DIVIDEND_W-1:0] div_quo;

  function automatic logic [Q_W-1:0] clamp_gain(logic [DIVIDEND_W-1:0] q,
                                                logic zero_div);
    logic [DIVIDEND_W-1:0] v;
    v = zero_div ? DIVIDEND_W'(GAIN_1X) : q;
    if (v > DIVIDEND_W'(GAIN_MAX))      return Q_W'(GAIN_MAX);
    else if (v < DIVIDEND_W'(GAIN_MIN)) return Q_W'(GAIN_MIN);
    else                                return v[Q_W-1:0];
  endfunction

  function automatic logic [Q_W-1:0] smooth(logic [Q_W-1:0] old_g,
                                            logic [Q_W-1:0] tgt);
    logic signed [Q_W:0] diff;
    logic signed [Q_W:0] sum;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, old_g});
    sum  = $signed({1'b0, old_g}) + (diff >>> SMOOTH_SHIFT);
    return sum[Q_W-1:0];
  endfunction

  assign div_start   = (state == S_START_R) || (state == S_START_B);
  assign div_divisor = (state == S_START_B) ? b_lat : r_lat;

  awb_seq_divider #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({g_lat, 8'b0}),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_lat      <= '0;
      g_lat      <= '0;
      b_lat      <= '0;
      r_tgt      <= GAIN_1X;
      b_tgt      <= GAIN_1X;
      r_gain     <= GAIN_1X;
      g_gain     <= GAIN_1X;
      b_gain     <= GAIN_1X;
      gain_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      gain_valid <= 1'b0;
      overrun    <= bus.frame_done_i && bus.enable_i && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.frame_done_i && bus.enable_i) begin
            r_lat <= bus.r_sum_i;
            g_lat <= bus.g_sum_i;
            b_lat <= bus.b_sum_i;
            busy  <= 1'b1;
            state <= S_START_R;
          end
        end
        S_START_R: state <= S_WAIT_R;
        S_WAIT_R: begin
          if (div_done) begin
            r_tgt <= clamp_gain(div_quo, r_lat == '0);
            state <= S_START_B;
          end
        end
        S_START_B: state <= S_WAIT_B;
        S_WAIT_B: begin
          if (div_done) begin
            b_tgt <= clamp_gain(div_quo, b_lat == '0);
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_gain     <= smooth(r_gain, r_tgt);
          b_gain     <= smooth(b_gain, b_tgt);
          g_gain     <= GAIN_1X;
          gain_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.r_gain_o     = r_gain;
  assign bus.g_gain_o     = g_gain;
  assign bus.b_gain_o     = b_gain;
  assign bus.gain_valid_o = gain_valid;
  assign bus.busy_o       = busy;
  assign bus.overrun_o    = overrun;

endmodule

// File: tb/tb_awb_gain_scheduler.sv
// Bench for awb_gain_scheduler: two instances (no smoothing, shift 2) share
// the same stimulus and are compared against an arithmetic reference model.
module tb_awb_gain_scheduler;

  localparam int LAT = 83;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  awb_gain_scheduler_if if0 ();
  awb_gain_scheduler_if if2 ();

  awb_gain_scheduler #(.SMOOTH_SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  awb_gain_scheduler #(.SMOOTH_SHIFT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int errors = 0;
  int checks = 0;
  int mr[2];
  int mb[2];
  int ks[2] = '{0, 2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_target(longint unsigned g, longint unsigned d);
    longint unsigned q;
    if (d == 0) return 256;
    q = (g * 256) / d;
    if (q > 1024) return 1024;
    if (q < 128) return 128;
    return int'(q);
  endfunction

  // old + floor((t-old) / 2^k)
  function automatic int model_smooth(int old, int t, int k);
    int d;
    int p;
    int step;
    d = t - old;
    p = 1 << k;
    if (d >= 0) step = d / p;
    else step = -((-d + p - 1) / p);
    return old + step;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic fd, input logic en,
                        input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    if0.frame_done_i = fd; if2.frame_done_i = fd;
    if0.enable_i = en;     if2.enable_i = en;
    if0.r_sum_i = r;       if2.r_sum_i = r;
    if0.g_sum_i = g;       if2.g_sum_i = g;
    if0.b_sum_i = b;       if2.b_sum_i = b;
  endtask

  task automatic check_gains(input string nm, input int r0, input int b0,
                             input int r2, input int b2);
    check({nm, " r0"}, 64'(if0.r_gain_o), 64'(r0));
    check({nm, " b0"}, 64'(if0.b_gain_o), 64'(b0));
    check({nm, " g0"}, 64'(if0.g_gain_o), 64'd256);
    check({nm, " r2"}, 64'(if2.r_gain_o), 64'(r2));
    check({nm, " b2"}, 64'(if2.b_gain_o), 64'(b2));
    check({nm, " g2"}, 64'(if2.g_gain_o), 64'd256);
  endtask

  // mode: 0 plain, 1 second frame_done at edge 10, 2 enable drops at edge 5,
  //       3 reset at edge 30
  task automatic run_frame(input logic [31:0] r, input logic [31:0] g,
                           input logic [31:0] b, input int mode, input string nm);
    int vcnt, vedge, bad, ovr, tr, tb;
    int er[2];
    int eb[2];
    vcnt = 0; vedge = -1; bad = 0; ovr = 0;
    tr = model_target(g, r);
    tb = model_target(g, b);
    for (int k = 0; k < 2; k++) begin
      er[k] = model_smooth(mr[k], tr, ks[k]);
      eb[k] = model_smooth(mb[k], tb, ks[k]);
    end
    set_in(1'b1, 1'b1, r, g, b);
    tick();
    check({nm, " busy_edge0"}, 64'(if0.busy_o), 64'd1);
    for (int n = 1; n <= LAT + 4; n++) begin
      set_in((mode == 1) && (n == 10), (mode != 2) || (n < 5), $urandom, $urandom, $urandom);
      if (mode == 3 && n == 30) rst = 1'b1;
      if (n == LAT) check({nm, " hold_before_commit"}, 64'(if2.r_gain_o), 64'(mr[1]));
      tick();
      if (if0.gain_valid_o) begin vcnt++; vedge = n; end
      if (if2.gain_valid_o !== if0.gain_valid_o) bad++;
      if (if0.busy_o !== (n < LAT) || if2.busy_o !== (n < LAT)) bad++;
      if (if0.overrun_o) ovr++;
      if (mode == 1 && n == 10) check({nm, " overrun_pulse"}, 64'(if0.overrun_o), 64'd1);
      if (n == LAT) check_gains(nm, er[0], eb[0], er[1], eb[1]);
      if (mode == 3 && n == 30) begin
        check({nm, " busy_after_rst"}, 64'(if0.busy_o | if2.busy_o), 64'd0);
        check_gains({nm, " rst"}, 256, 256, 256, 256);
        mr = '{256, 256};
        mb = '{256, 256};
        rst = 1'b0;
        set_in(1'b0, 1'b1, '0, '0, '0);
        for (int j = 0; j < 5; j++) begin
          tick();
          if (if0.gain_valid_o || if2.gain_valid_o || if0.busy_o) vcnt++;
        end
        check({nm, " quiet_after_rst"}, 64'(vcnt), 64'd0);
        return;
      end
    end
    check({nm, " valid_edge"}, 64'(vedge), 64'(LAT));
    check({nm, " valid_count"}, 64'(vcnt), 64'd1);
    check({nm, " busy_valid_window"}, 64'(bad), 64'd0);
    check({nm, " overrun_count"}, 64'(ovr), (mode == 1) ? 64'd1 : 64'd0);
    for (int k = 0; k < 2; k++) begin
      mr[k] = er[k];
      mb[k] = eb[k];
    end
  endtask

  initial begin
    int quiet;
    logic [31:0] rr, gg, bb;
    set_in(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_gains("reset", 256, 256, 256, 256);
    check("reset valid", 64'(if0.gain_valid_o | if2.gain_valid_o), 64'd0);
    check("reset busy", 64'(if0.busy_o | if2.busy_o), 64'd0);
    check("reset overrun", 64'(if0.overrun_o | if2.overrun_o), 64'd0);
    mr = '{256, 256};
    mb = '{256, 256};

    run_frame(32'd1000, 32'd2000, 32'd2000, 0, "smooth1");
    check("smooth1 r2 direct", 64'(if2.r_gain_o), 64'd320);
    run_frame(32'd1000, 32'd2000, 32'd2000, 0, "smooth2");
    check("smooth2 r2 direct", 64'(if2.r_gain_o), 64'd368);
    run_frame(32'd1000, 32'd2000, 32'd4000, 0, "basic");
    check("basic r0 direct", 64'(if0.r_gain_o), 64'd512);
    check("basic b0 direct", 64'(if0.b_gain_o), 64'd128);
    run_frame(32'd100, 32'd1000, 32'd0, 0, "clamp_zero");
    check("clamp r0 direct", 64'(if0.r_gain_o), 64'd1024);
    check("zero b0 direct", 64'(if0.b_gain_o), 64'd256);
    run_frame(32'd3000, 32'd2000, 32'd1500, 1, "overrun");

    // frame_done with enable low is ignored entirely
    set_in(1'b1, 1'b0, 32'd10, 32'd5000, 32'd10);
    tick();
    set_in(1'b0, 1'b1, '0, '0, '0);
    quiet = 0;
    for (int j = 0; j < 6; j++) begin
      if (if0.busy_o || if0.overrun_o || if0.gain_valid_o) quiet++;
      tick();
    end
    check("disabled frame ignored", 64'(quiet), 64'd0);
    check_gains("disabled hold", mr[0], mb[0], mr[1], mb[1]);

    run_frame(32'd700, 32'd1000, 32'd5000, 2, "enable_drop");
    run_frame(32'd500, 32'd1000, 32'd900, 3, "rst_mid");
    run_frame(32'd1000, 32'd2000, 32'd4000, 0, "after_rst");

    for (int i = 0; i < 8; i++) begin
      gg = $urandom;
      rr = (i % 4 == 0) ? 32'd0 : (gg >> $urandom_range(0, 3)) + 32'($urandom_range(0, 1000));
      bb = (i % 3 == 0) ? 32'($urandom_range(1, 1 << 20)) : (gg >> $urandom_range(0, 3));
      run_frame(rr, gg, bb, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/awb_gain_scheduler.md
# awb_gain_scheduler

Sequential replacement for the AWB gain computation stage, sitting between AWB statistics and the P2_MWB gain-apply module. On each frame-done it latches the R/G/B channel sums and computes R_gain = (G_sum<<8)/R_sum, then B_gain = (G_sum<<8)/B_sum, on one shared iterative divider. It saturates each result to [GAIN_MIN, GAIN_MAX], applies first-order IIR smoothing, and commits all three Q8.8 gains atomically. The fixed multi-cycle latency replaces two 40/32-bit combinational dividers.

## Interface
- GAIN_MIN, 128, lower clamp, Q8.8 (0.5x)
- GAIN_MAX, 1024, upper clamp, Q8.8 (4.0x)
- SMOOTH_SHIFT, 2, IIR shift k; 0 = no smoothing (commit target directly)
- DIV_CYCLES, 40, divider iterations (= dividend width)

- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- enable_i  in  1  0 = ignore frame_done_i, hold gains
- frame_done_i  in  1  one-cycle pulse; sums valid in that cycle
- r_sum_i / g_sum_i / b_sum_i  in  32 each  channel sums
- r_gain_o / g_gain_o / b_gain_o  out  16 each  Q8.8 gains
- gain_valid_o  out  1  one-cycle pulse when gains update
- busy_o  out  1  high whenever state != IDLE
- overrun_o  out  1  one-cycle pulse when frame_done_i is dropped

## Operation
- Reset values:
  - All gains = 256.
  - gain_valid_o, busy_o, overrun_o = 0.
  - State = IDLE, divider idle.
- FSM: IDLE -> START_R -> WAIT_R -> START_B -> WAIT_B -> COMMIT -> IDLE.
  - IDLE: if frame_done_i && enable_i, register the three sums and go to START_R.
  - START_R / START_B: one cycle; pulse divider start with dividend {g_sum,8'b0} (40 b) and divisor r_sum or b_sum.
  - WAIT_x: hold until divider done; then capture the quotient.
  - COMMIT: one cycle; outputs are written on the exiting edge.
- Divider quotient is 40 b.
  - If the quotient > GAIN_MAX (any upper bit set included), target = GAIN_MAX.
  - If the quotient < GAIN_MIN, target = GAIN_MIN.
  - Otherwise target = quotient[15:0].
- Divisor == 0: the divider still runs, for a fixed latency, but target = 256 (then clamped, then smoothed).
- Smoothing, in 17-bit signed arithmetic: new = old + ((target - old) >>> SMOOTH_SHIFT).
  - The arithmetic shift rounds toward minus infinity.
  - The result always lies within [GAIN_MIN, GAIN_MAX] when old is within that range.
- g_gain_o is rewritten to 256 at every COMMIT.
- frame_done_i while busy_o = 1: the event is dropped, overrun_o pulses the next cycle, and the computation in progress is unaffected.
- frame_done_i while enable_i = 0: ignored, no overrun_o.
- enable_i falling mid-computation: the computation completes and commits.
- rst asserted mid-computation: return to IDLE next edge, gains = 256, no gain_valid_o pulse.

## Timing
- Edge 0 samples frame_done_i and the sums.
- The divider runs DIV_CYCLES cycles per division.
- Gains and gain_valid_o update on edge LAT = 2*(DIV_CYCLES+1)+1 = 83 with the defaults.
- busy_o is high from the cycle after edge 0 through the cycle before edge LAT.
- The earliest accepted next frame_done_i is in the cycle after edge LAT.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package awb_pkg:
  - GAIN_1X = 256.
  - Q8.8 width = 16.
  - Sum width = 32.
  - Dividend width = 40.
  - FSM state enum.
- Sub-module awb_seq_divider: restoring radix-2, unsigned 40/32 divider.
  - Interface: start, dividend, divisor, done (one-cycle pulse exactly DIV_CYCLES cycles after start), quotient (40 b).
  - No divide-by-zero handling inside; the caller overrides the result.

## Test plan
- **Reset defaults:** assert rst for 2 cycles, then idle. Required: all gains = 256; valid, busy and overrun = 0.
- **Basic update, SMOOTH_SHIFT=0:** r=1000, g=2000, b=4000. Required: at edge 83, r_gain=512, b_gain=128, g_gain=256, gain_valid_o = one pulse.
- **Clamping and zero divisor:** r=100, g=1000, b=0. Required: r_gain=1024 (raw 2560 saturated), b_gain=256.
- **Smoothing, SMOOTH_SHIFT=2, old=256:** target 512 with r=1000, g=2000. Required: r_gain=320; repeating the same frame gives 368.
- **Overrun:** a second frame_done_i at edge 10. Required: overrun_o pulse at edge 11; the first result commits at edge 83; only one gain_valid_o pulse.
- **Reset mid-operation:** rst at edge 30. Required: IDLE and gains 256 by the next edge, busy_o = 0, no gain_valid_o; a new frame afterwards commits 83 edges after its frame_done_i.
